// File: rtl/sc_fault_manager.sv
// sc_fault_manager: debounces safety-monitor faults, latches the first
// qualified code, gates charging through a cooldown, hints derating on
// unstable-grid codes and keeps a saturating count plus a history FIFO.
module sc_fault_manager #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COOLDOWN_CYCLES = 1000,
   parameter int LOG_DEPTH       = 8,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fault_flag,
   input  logic [3:0]       fault_code,
   input  logic             clear_req,
   input  logic             log_rd,
   output logic             charge_enable,
   output logic             derate,
   output logic             fault_latched,
   output logic             cooldown_active,
   output logic [3:0]       latched_code,
   output logic [CNT_W-1:0] fault_count,
   output logic             log_empty,
   output logic [3:0]       log_code,
   output logic             log_overflow
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);
   localparam int PTR_W = $clog2(LOG_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_OK, ST_PENDING, ST_LATCHED, ST_COOLDOWN} state_t;

   state_t            state, state_nxt;
   logic [DB_W-1:0]   db_cnt, db_nxt;
   logic [CD_W-1:0]   cd_tmr, cd_nxt;
   logic [3:0]        code_nxt;
   logic              latch_evt;

   logic [3:0]        mem [LOG_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [OCC_W-1:0]  occ;
   logic              push, pop, full;

   // Next-state logic: debounce, latch, clear handshake and cooldown timing
   always_comb begin
      state_nxt = state;
      db_nxt    = db_cnt;
      cd_nxt    = cd_tmr;
      code_nxt  = latched_code;
      latch_evt = 1'b0;
      case (state)
         ST_OK: begin
            db_nxt = '0;
            if (fault_flag) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = ST_LATCHED;
                  latch_evt = 1'b1;
                  code_nxt  = fault_code;
               end else begin
                  state_nxt = ST_PENDING;
                  db_nxt    = DB_W'(1);
               end
            end
         end
         ST_PENDING: begin
            if (!fault_flag) begin
               // no partial credit: any gap restarts qualification
               state_nxt = ST_OK;
               db_nxt    = '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               state_nxt = ST_LATCHED;
               latch_evt = 1'b1;
               code_nxt  = fault_code;
               db_nxt    = '0;
            end else begin
               db_nxt = db_cnt + 1'b1;
            end
         end
         ST_LATCHED: begin
            // a clear is only honoured once the fault has gone away
            if (clear_req && !fault_flag) begin
               state_nxt = ST_COOLDOWN;
               cd_nxt    = '0;
            end
         end
         ST_COOLDOWN: begin
            // a returning fault wins over timer expiry and skips debounce
            if (fault_flag) begin
               state_nxt = ST_LATCHED;
               latch_evt = 1'b1;
               code_nxt  = fault_code;
            end else if (cd_tmr == CD_W'(COOLDOWN_CYCLES - 1)) begin
               state_nxt = ST_OK;
               code_nxt  = 4'h0;
               cd_nxt    = '0;
            end else begin
               cd_nxt = cd_tmr + 1'b1;
            end
         end
         default: state_nxt = ST_OK;
      endcase
   end

   // State, timers and registered status outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= ST_OK;
         db_cnt          <= '0;
         cd_tmr          <= '0;
         latched_code    <= 4'h0;
         fault_count     <= '0;
         charge_enable   <= 1'b1;
         fault_latched   <= 1'b0;
         cooldown_active <= 1'b0;
         derate          <= 1'b0;
      end else begin
         state           <= state_nxt;
         db_cnt          <= db_nxt;
         cd_tmr          <= cd_nxt;
         latched_code    <= code_nxt;
         if (latch_evt && (fault_count != {CNT_W{1'b1}}))
            fault_count <= fault_count + 1'b1;
         charge_enable   <= (state_nxt == ST_OK) || (state_nxt == ST_PENDING);
         fault_latched   <= (state_nxt == ST_LATCHED);
         cooldown_active <= (state_nxt == ST_COOLDOWN);
         derate          <= (state == ST_OK) && !fault_flag &&
                            ((fault_code == 4'b0010) || (fault_code == 4'b0110));
      end
   end

   assign push = latch_evt;
   assign pop  = log_rd && (occ != '0);
   assign full = (occ == OCC_W'(LOG_DEPTH));

   // History storage; content needs no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= code_nxt;
   end

   // FIFO pointers/occupancy; a push into a full FIFO evicts the oldest entry
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occ          <= '0;
         log_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (push && pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end else if (push && full) begin
            rd_ptr       <= rd_ptr + 1'b1;
            log_overflow <= 1'b1;
         end else if (push) begin
            occ <= occ + 1'b1;
         end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            occ    <= occ - 1'b1;
         end
      end
   end

   assign log_empty = (occ == '0);
   assign log_code  = log_empty ? 4'h0 : mem[rd_ptr];

endmodule

// File: tb/tb_sc_fault_manager.sv
// Directed bench for sc_fault_manager: a default-parameter instance and a
// small instance (DEBOUNCE=1, COOLDOWN=2, LOG_DEPTH=2, CNT_W=2).
module tb_sc_fault_manager;

   logic clk, reset_n;
   logic fault_flag, clear_req, log_rd;
   logic [3:0] fault_code;
   logic charge_enable, derate, fault_latched, cooldown_active, log_empty, log_overflow;
   logic [3:0] latched_code, log_code;
   logic [7:0] fault_count;

   logic f2_flag, f2_clear, f2_rd;
   logic [3:0] f2_code;
   logic ce2, der2, fl2, cd2, le2, ov2;
   logic [3:0] lc2, lcode2;
   logic [1:0] fc2;

   int errors = 0;
   int checks = 0;

   sc_fault_manager dut (
      .clk(clk), .reset_n(reset_n), .fault_flag(fault_flag), .fault_code(fault_code),
      .clear_req(clear_req), .log_rd(log_rd), .charge_enable(charge_enable), .derate(derate),
      .fault_latched(fault_latched), .cooldown_active(cooldown_active),
      .latched_code(latched_code), .fault_count(fault_count), .log_empty(log_empty),
      .log_code(log_code), .log_overflow(log_overflow));

   sc_fault_manager #(.DEBOUNCE_CYCLES(1), .COOLDOWN_CYCLES(2), .LOG_DEPTH(2), .CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .fault_flag(f2_flag), .fault_code(f2_code),
      .clear_req(f2_clear), .log_rd(f2_rd), .charge_enable(ce2), .derate(der2),
      .fault_latched(fl2), .cooldown_active(cd2), .latched_code(lc2), .fault_count(fc2),
      .log_empty(le2), .log_code(lcode2), .log_overflow(ov2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      steps(2);
      checks++; if (charge_enable !== 1'b1) begin errors++; $display("FAIL reset_ce got=%0b exp=1", charge_enable); end
      checks++; if ({derate, fault_latched, cooldown_active} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {derate, fault_latched, cooldown_active}); end
      checks++; if (latched_code !== 4'h0) begin errors++; $display("FAIL reset_lc got=%h exp=0", latched_code); end
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fault_count); end
      checks++; if ({log_empty, log_code, log_overflow} !== 6'b1_0000_0) begin errors++; $display("FAIL reset_log got=%b exp=100000", {log_empty, log_code, log_overflow}); end
      checks++; if ({ce2, fl2, fc2, le2} !== 5'b1_0_00_1) begin errors++; $display("FAIL reset_dut2 got=%b exp=10001", {ce2, fl2, fc2, le2}); end
      reset_n = 1'b1;
   endtask

   task automatic test_short_pulse();
      fault_flag = 1'b1; fault_code = 4'h1;
      steps(3);
      fault_flag = 1'b0;
      step();
      checks++; if (charge_enable !== 1'b1) begin errors++; $display("FAIL short_ce got=%0b exp=1", charge_enable); end
      checks++; if (fault_latched !== 1'b0) begin errors++; $display("FAIL short_fl got=%0b exp=0", fault_latched); end
      checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL short_cnt got=%0d exp=0", fault_count); end
   endtask

   task automatic test_latch();
      fault_flag = 1'b1; fault_code = 4'h5;
      steps(3);
      checks++; if ({fault_latched, charge_enable} !== 2'b01) begin errors++; $display("FAIL latch_early got=%b exp=01", {fault_latched, charge_enable}); end
      step();
      checks++; if (fault_latched !== 1'b1) begin errors++; $display("FAIL latch_fl got=%0b exp=1", fault_latched); end
      checks++; if (latched_code !== 4'h5) begin errors++; $display("FAIL latch_lc got=%h exp=5", latched_code); end
      checks++; if (charge_enable !== 1'b0) begin errors++; $display("FAIL latch_ce got=%0b exp=0", charge_enable); end
      checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL latch_cnt got=%0d exp=1", fault_count); end
      checks++; if ({log_empty, log_code} !== 5'b0_0101) begin errors++; $display("FAIL latch_log got=%b exp=00101", {log_empty, log_code}); end
   endtask

   task automatic test_clear_blocked();
      clear_req = 1'b1;
      steps(2);
      checks++; if ({fault_latched, cooldown_active} !== 2'b10) begin errors++; $display("FAIL clrblk got=%b exp=10", {fault_latched, cooldown_active}); end
   endtask

   task automatic test_cooldown();
      fault_flag = 1'b0;
      step();
      clear_req = 1'b0;
      checks++; if ({cooldown_active, charge_enable, latched_code} !== 6'b10_0101) begin errors++; $display("FAIL cd_entry got=%b exp=100101", {cooldown_active, charge_enable, latched_code}); end
      steps(999);
      checks++; if (cooldown_active !== 1'b1) begin errors++; $display("FAIL cd_last got=%0b exp=1", cooldown_active); end
      step();
      checks++; if ({charge_enable, cooldown_active, fault_latched} !== 3'b100) begin errors++; $display("FAIL cd_exit got=%b exp=100", {charge_enable, cooldown_active, fault_latched}); end
      checks++; if (latched_code !== 4'h0) begin errors++; $display("FAIL cd_exit_lc got=%h exp=0", latched_code); end
   endtask

   task automatic test_relatch();
      fault_flag = 1'b1; fault_code = 4'h3;
      steps(4);
      checks++; if ({fault_latched, latched_code, fault_count} !== {1'b1, 4'h3, 8'd2}) begin errors++; $display("FAIL relatch_2nd got=%b %h %0d exp=1 3 2", fault_latched, latched_code, fault_count); end
      fault_flag = 1'b0; clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      steps(499);
      fault_flag = 1'b1; fault_code = 4'h4;
      step();
      checks++; if ({fault_latched, cooldown_active, latched_code} !== 6'b10_0100) begin errors++; $display("FAIL relatch_cd got=%b exp=100100", {fault_latched, cooldown_active, latched_code}); end
      checks++; if (fault_count !== 8'd3) begin errors++; $display("FAIL relatch_cnt got=%0d exp=3", fault_count); end
      // fault on the final cooldown cycle beats expiry
      fault_flag = 1'b0; clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      steps(999);
      checks++; if (cooldown_active !== 1'b1) begin errors++; $display("FAIL prio_pre got=%0b exp=1", cooldown_active); end
      fault_flag = 1'b1; fault_code = 4'h7;
      step();
      checks++; if ({fault_latched, charge_enable, latched_code, fault_count} !== {1'b1, 1'b0, 4'h7, 8'd4}) begin errors++; $display("FAIL prio got=%b %b %h %0d exp=1 0 7 4", fault_latched, charge_enable, latched_code, fault_count); end
   endtask

   task automatic test_fifo_pop();
      logic [3:0] exp_q [4];
      exp_q[0] = 4'h5; exp_q[1] = 4'h3; exp_q[2] = 4'h4; exp_q[3] = 4'h7;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({log_empty, log_code} !== {1'b0, exp_q[i]}) begin errors++; $display("FAIL pop_%0d got=%b %h exp=0 %h", i, log_empty, log_code, exp_q[i]); end
         log_rd = 1'b1; step(); log_rd = 1'b0;
      end
      checks++; if ({log_empty, log_code} !== 5'b1_0000) begin errors++; $display("FAIL pop_empty got=%b exp=10000", {log_empty, log_code}); end
      log_rd = 1'b1; step(); log_rd = 1'b0;
      checks++; if ({log_empty, log_overflow} !== 2'b10) begin errors++; $display("FAIL pop_on_empty got=%b exp=10", {log_empty, log_overflow}); end
   endtask

   task automatic test_overflow();
      fault_flag = 1'b0; clear_req = 1'b1;
      step();
      for (int i = 1; i <= 9; i++) begin
         clear_req = 1'b0; fault_flag = 1'b1; fault_code = 4'(i);
         step();
         fault_flag = 1'b0; clear_req = 1'b1;
         step();
         if (i == 8) begin
            checks++; if ({log_overflow, log_code} !== 5'b0_0001) begin errors++; $display("FAIL ovf_full got=%b exp=00001", {log_overflow, log_code}); end
         end
      end
      clear_req = 1'b0;
      checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", log_overflow); end
      checks++; if (fault_count !== 8'd13) begin errors++; $display("FAIL ovf_cnt got=%0d exp=13", fault_count); end
      for (int i = 2; i <= 9; i++) begin
         checks++; if ({log_empty, log_code} !== {1'b0, 4'(i)}) begin errors++; $display("FAIL ovf_pop_%0d got=%b %h exp=0 %h", i, log_empty, log_code, 4'(i)); end
         log_rd = 1'b1; step(); log_rd = 1'b0;
      end
      checks++; if ({log_empty, log_overflow} !== 2'b11) begin errors++; $display("FAIL ovf_drained got=%b exp=11", {log_empty, log_overflow}); end
   endtask

   task automatic test_derate();
      fault_flag = 1'b0; fault_code = 4'h0;
      steps(1000);
      checks++; if ({charge_enable, cooldown_active, derate} !== 3'b100) begin errors++; $display("FAIL der_ok got=%b exp=100", {charge_enable, cooldown_active, derate}); end
      fault_code = 4'h6; step();
      checks++; if (derate !== 1'b1) begin errors++; $display("FAIL der_6 got=%0b exp=1", derate); end
      fault_code = 4'h2; step();
      checks++; if (derate !== 1'b1) begin errors++; $display("FAIL der_2 got=%0b exp=1", derate); end
      fault_code = 4'h7; step();
      checks++; if (derate !== 1'b0) begin errors++; $display("FAIL der_7 got=%0b exp=0", derate); end
      fault_code = 4'h6; fault_flag = 1'b1; step();
      checks++; if (derate !== 1'b0) begin errors++; $display("FAIL der_flag got=%0b exp=0", derate); end
      fault_flag = 1'b0; step();
      checks++; if (derate !== 1'b0) begin errors++; $display("FAIL der_pend got=%0b exp=0", derate); end
      step();
      checks++; if (derate !== 1'b1) begin errors++; $display("FAIL der_back got=%0b exp=1", derate); end
      fault_code = 4'h0;
   endtask

   task automatic test_small_cfg();
      // L1: push with pop on empty FIFO, immediate latch (no debounce)
      f2_flag = 1'b1; f2_code = 4'h1; f2_rd = 1'b1; step();
      f2_flag = 1'b0; f2_rd = 1'b0;
      checks++; if ({fl2, lc2, fc2, le2, lcode2} !== {1'b1, 4'h1, 2'd1, 1'b0, 4'h1}) begin errors++; $display("FAIL s_l1 got=%b %h %0d %b %h exp=1 1 1 0 1", fl2, lc2, fc2, le2, lcode2); end
      f2_clear = 1'b1; step(); f2_clear = 1'b0;
      step();
      checks++; if ({cd2, ce2} !== 2'b10) begin errors++; $display("FAIL s_cd got=%b exp=10", {cd2, ce2}); end
      step();
      checks++; if ({cd2, ce2, lc2} !== 6'b01_0000) begin errors++; $display("FAIL s_cd_exit got=%b exp=010000", {cd2, ce2, lc2}); end
      // L2: push with pop on one entry -> occupancy stays 1
      f2_flag = 1'b1; f2_code = 4'h2; f2_rd = 1'b1; step();
      f2_flag = 1'b0; f2_rd = 1'b0; f2_clear = 1'b1; step(); f2_clear = 1'b0;
      // L3: fills FIFO, counter saturates
      f2_flag = 1'b1; f2_code = 4'h3; step();
      f2_flag = 1'b0; f2_clear = 1'b1; step(); f2_clear = 1'b0;
      checks++; if ({fc2, ov2, lcode2} !== {2'd3, 1'b0, 4'h2}) begin errors++; $display("FAIL s_l3 got=%0d %b %h exp=3 0 2", fc2, ov2, lcode2); end
      // L4: push with pop on full FIFO -> no overflow
      f2_flag = 1'b1; f2_code = 4'h4; f2_rd = 1'b1; step();
      f2_flag = 1'b0; f2_rd = 1'b0; f2_clear = 1'b1; step(); f2_clear = 1'b0;
      checks++; if ({ov2, lcode2} !== 5'b0_0011) begin errors++; $display("FAIL s_l4 got=%b exp=00011", {ov2, lcode2}); end
      // L5: push on full FIFO -> oldest dropped, overflow, count stays 3
      f2_flag = 1'b1; f2_code = 4'h5; step();
      f2_flag = 1'b0;
      checks++; if ({fc2, ov2, lcode2} !== {2'd3, 1'b1, 4'h4}) begin errors++; $display("FAIL s_l5 got=%0d %b %h exp=3 1 4", fc2, ov2, lcode2); end
      f2_rd = 1'b1; step();
      checks++; if ({le2, lcode2} !== 5'b0_0101) begin errors++; $display("FAIL s_pop1 got=%b exp=00101", {le2, lcode2}); end
      step(); f2_rd = 1'b0;
      checks++; if ({le2, lcode2} !== 5'b1_0000) begin errors++; $display("FAIL s_pop2 got=%b exp=10000", {le2, lcode2}); end
   endtask

   task automatic test_reset_mid();
      fault_flag = 1'b1; fault_code = 4'h9;
      steps(4);
      checks++; if ({fault_latched, fault_count} !== {1'b1, 8'd14}) begin errors++; $display("FAIL mid_pre got=%b %0d exp=1 14", fault_latched, fault_count); end
      reset_n = 1'b0; step();
      checks++; if ({charge_enable, fault_latched, latched_code, fault_count} !== {1'b1, 1'b0, 4'h0, 8'd0}) begin errors++; $display("FAIL mid_rst got=%b %b %h %0d exp=1 0 0 0", charge_enable, fault_latched, latched_code, fault_count); end
      checks++; if ({log_empty, log_code, log_overflow, ov2, le2} !== 8'b1_0000_0_0_1) begin errors++; $display("FAIL mid_rst_log got=%b exp=10000001", {log_empty, log_code, log_overflow, ov2, le2}); end
      fault_flag = 1'b0; reset_n = 1'b1; step();
   endtask

   initial begin
      reset_n = 1'b0; fault_flag = 1'b0; fault_code = 4'h0; clear_req = 1'b0; log_rd = 1'b0;
      f2_flag = 1'b0; f2_code = 4'h0; f2_clear = 1'b0; f2_rd = 1'b0;
      test_reset();
      test_short_pulse();
      test_latch();
      test_clear_blocked();
      test_cooldown();
      test_relatch();
      test_fifo_pop();
      test_overflow();
      test_derate();
      test_small_cfg();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sc_fault_manager.md
Name: sc_fault_manager

Overview:
- Sits directly downstream of the safety monitor and consumes its combinational fault_flag/fault_code pair.
- Debounces faults and latches the first qualified fault code.
- Gates charging, enforces a cooldown before re-enable, drives a derate hint for unstable-grid codes, and keeps a saturating fault counter plus a small fault-history FIFO for the host.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive high fault_flag samples needed to latch (>=1).
- COOLDOWN_CYCLES, 1000, cycles spent in COOLDOWN before charging is re-enabled (>=1).
- LOG_DEPTH, 8, fault-history FIFO entries (power of 2, >=2).
- CNT_W, 8, fault counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- fault_flag  in  1  fault request from the safety monitor
- fault_code  in  4  fault code from the safety monitor
- clear_req  in  1  host clear request (level, sampled each cycle)
- log_rd  in  1  pop the head of the fault-history FIFO
- charge_enable  out  1  1 = charging permitted
- derate  out  1  1 = reduce charge current (unstable grid)
- fault_latched  out  1  1 in LATCHED state
- cooldown_active  out  1  1 in COOLDOWN state
- latched_code  out  4  code captured at latch time
- fault_count  out  CNT_W  saturating count of latch events
- log_empty  out  1  FIFO empty
- log_code  out  4  FIFO head (first-word fall-through; 0 when empty)
- log_overflow  out  1  sticky: an entry was dropped

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=OK, all counters and FIFO pointers cleared.
  - charge_enable=1, derate=0, fault_latched=0, cooldown_active=0, latched_code=0, fault_count=0, log_empty=1, log_code=0, log_overflow=0.
  - Reset mid-operation aborts any state immediately.
- All outputs are registered and reflect the state one cycle after the input edge that caused it.
- FSM states: OK, PENDING, LATCHED, COOLDOWN.
- OK:
  - fault_flag=1 -> debounce count=1.
  - If DEBOUNCE_CYCLES=1, go to LATCHED; otherwise go to PENDING.
- PENDING:
  - fault_flag=1 -> count++.
  - When the count reaches DEBOUNCE_CYCLES, go to LATCHED and capture the fault_code sampled on that cycle.
  - fault_flag=0 -> OK, count cleared. There is no partial credit.
- LATCHED:
  - clear_req=1 and fault_flag=0 -> COOLDOWN, cooldown timer loaded with 0.
  - clear_req while fault_flag=1 is ignored.
- COOLDOWN:
  - Timer increments each cycle; at COOLDOWN_CYCLES-1 -> OK, latched_code cleared to 0.
  - fault_flag=1 in any COOLDOWN cycle -> LATCHED immediately, with no debounce.
  - That re-latch captures the new code and counts as a latch event.
  - fault_flag has priority over timer expiry on the same cycle.
- Latch event (any entry to LATCHED):
  - fault_count++, saturating at 2^CNT_W-1.
  - The captured code is pushed into the FIFO.
- Output decode:
  - charge_enable=1 in OK and PENDING, 0 in LATCHED and COOLDOWN.
  - fault_latched=1 in LATCHED only; cooldown_active=1 in COOLDOWN only.
  - derate=1 only in state OK with fault_flag=0 and fault_code in {0010, 0110}, registered; otherwise 0.
- FIFO:
  - The head is visible on log_code whenever non-empty.
  - log_rd on empty is ignored.
  - Push when full: drop the oldest entry, write the new one, set log_overflow; the occupancy stays LOG_DEPTH.
  - Simultaneous push and pop:
    - When full: pop then push, no overflow.
    - When non-empty: occupancy unchanged.
    - When empty: the pop is ignored and the push is taken.
  - log_overflow clears only on reset.

Test Plan:
- Reset with all inputs 0 -> charge_enable=1, fault_count=0, log_empty=1, all other outputs 0.
- fault_flag=1 with code 0001 for 3 cycles, then 0 -> stays OK, charge_enable stays 1, fault_count=0.
- fault_flag=1 with code 0101 for 4 cycles -> next cycle fault_latched=1, latched_code=0101, charge_enable=0, fault_count=1, log_code=0101.
- Latched, then clear_req=1 with fault_flag=1 -> stays LATCHED.
- Then drop fault_flag -> COOLDOWN for 1000 cycles -> charge_enable=1 and latched_code=0.
- In COOLDOWN at cycle 500, fault_flag=1 with code 0100 -> LATCHED next cycle, fault_count incremented, FIFO entry 0100.
- 9 latch events with codes 1..9 and LOG_DEPTH=8 -> log_overflow=1; popping yields 2..9, then log_empty=1.
- State OK, fault_flag=0, code 0110 -> derate=1 next cycle; code 0111 -> derate=0.
- Set CNT_W=2 and drive 5 latches -> fault_count=3.
